execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 168 ++++++++++++++++
 tb/tb_execute_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU ops plus a 16-iteration shift-add multiplier.
// The multiplier stalls upstream while busy and retires its result on the last iteration.
module execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode_in,
  input  logic [15:0] operand1_in,
  input  logic [15:0] operand2_in,
  input  logic [3:0]  reg_addr_in,
  input  logic        write_enable_in,
  input  logic        store_enable_in,
  input  logic        load_enable_in,
  input  logic [3:0]  mem_addr_in,
  output logic [15:0] alu_result_out,
  output logic [15:0] store_data_out,
  output logic [3:0]  reg_addr_out,
  output logic        write_enable_out,
  output logic        store_enable_out,
  output logic        load_enable_out,
  output logic [3:0]  mem_addr_out,
  output logic        zero_flag_out,
  output logic        carry_flag_out,
  output logic        valid_out,
  output logic        stall_out
);

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_MUL = 4'h9;
  localparam logic [3:0] OP_LD  = 4'hA;
  localparam logic [3:0] OP_ST  = 4'hB;
  localparam logic [3:0] OP_MOV = 4'hC;

  typedef enum logic {
    S_IDLE,
    S_MUL_BUSY
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [15:0] r_mplier;
  logic [3:0]  r_mul_rd;
  logic        r_mul_we;

  logic [16:0] w_sum;
  logic [15:0] w_res;
  logic        w_carry;
  logic        w_retire;
  logic [31:0] w_prod_next;
  logic        w_is_store;

  assign w_sum = {1'b0, operand1_in} + {1'b0, operand2_in};
  assign w_prod_next = r_acc + (r_mplier[0] ? r_mcand : 32'd0);
  assign w_is_store = (opcode_in == OP_ST);

  always_comb begin
    w_res    = '0;
    w_carry  = 1'b0;
    w_retire = 1'b1;
    case (opcode_in)
      OP_ADD: begin
        w_res   = w_sum[15:0];
        w_carry = w_sum[16];
      end
      OP_SUB: begin
        w_res   = operand1_in - operand2_in;
        w_carry = (operand1_in < operand2_in);
      end
      OP_AND: w_res = operand1_in & operand2_in;
      OP_OR:  w_res = operand1_in | operand2_in;
      OP_XOR: w_res = operand1_in ^ operand2_in;
      OP_NOT: w_res = ~operand1_in;
      OP_SHL: w_res = operand1_in << operand2_in[3:0];
      OP_SHR: w_res = operand1_in >> operand2_in[3:0];
      OP_LD:  w_res = '0;
      OP_ST:  w_res = '0;
      OP_MOV: w_res = operand2_in;
      // NOP, MUL and reserved codes do not retire from here
      default: w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_acc            <= '0;
      r_mcand          <= '0;
      r_mplier         <= '0;
      r_mul_rd         <= '0;
      r_mul_we         <= 1'b0;
      alu_result_out   <= '0;
      store_data_out   <= '0;
      reg_addr_out     <= '0;
      write_enable_out <= 1'b0;
      store_enable_out <= 1'b0;
      load_enable_out  <= 1'b0;
      mem_addr_out     <= '0;
      zero_flag_out    <= 1'b0;
      carry_flag_out   <= 1'b0;
      valid_out        <= 1'b0;
      stall_out        <= 1'b0;
    end else begin
      // bubble by default; retiring paths override below
      alu_result_out   <= '0;
      store_data_out   <= '0;
      reg_addr_out     <= '0;
      write_enable_out <= 1'b0;
      store_enable_out <= 1'b0;
      load_enable_out  <= 1'b0;
      mem_addr_out     <= '0;
      zero_flag_out    <= 1'b0;
      carry_flag_out   <= 1'b0;
      valid_out        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (opcode_in == OP_MUL) begin
            r_state   <= S_MUL_BUSY;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= {16'd0, operand1_in};
            r_mplier  <= operand2_in;
            r_mul_rd  <= reg_addr_in;
            r_mul_we  <= write_enable_in;
            stall_out <= 1'b1;
          end else if (w_retire) begin
            alu_result_out   <= w_res;
            store_data_out   <= w_is_store ? operand1_in : 16'd0;
            reg_addr_out     <= reg_addr_in;
            write_enable_out <= write_enable_in;
            store_enable_out <= store_enable_in;
            load_enable_out  <= load_enable_in;
            mem_addr_out     <= mem_addr_in;
            zero_flag_out    <= (w_res == 16'd0);
            carry_flag_out   <= w_carry;
            valid_out        <= 1'b1;
          end
        end
        S_MUL_BUSY: begin
          r_acc    <= w_prod_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state          <= S_IDLE;
            stall_out        <= 1'b0;
            alu_result_out   <= w_prod_next[15:0];
            carry_flag_out   <= |w_prod_next[31:16];
            zero_flag_out    <= (w_prod_next[15:0] == 16'd0);
            reg_addr_out     <= r_mul_rd;
            write_enable_out <= r_mul_we;
            valid_out        <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed vector table, multiply corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode_in;
  logic [15:0] operand1_in;
  logic [15:0] operand2_in;
  logic [3:0]  reg_addr_in;
  logic        write_enable_in;
  logic        store_enable_in;
  logic        load_enable_in;
  logic [3:0]  mem_addr_in;
  logic [15:0] alu_result_out;
  logic [15:0] store_data_out;
  logic [3:0]  reg_addr_out;
  logic        write_enable_out;
  logic        store_enable_out;
  logic        load_enable_out;
  logic [3:0]  mem_addr_out;
  logic        zero_flag_out;
  logic        carry_flag_out;
  logic        valid_out;
  logic        stall_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk              (clk),
    .reset            (reset),
    .opcode_in        (opcode_in),
    .operand1_in      (operand1_in),
    .operand2_in      (operand2_in),
    .reg_addr_in      (reg_addr_in),
    .write_enable_in  (write_enable_in),
    .store_enable_in  (store_enable_in),
    .load_enable_in   (load_enable_in),
    .mem_addr_in      (mem_addr_in),
    .alu_result_out   (alu_result_out),
    .store_data_out   (store_data_out),
    .reg_addr_out     (reg_addr_out),
    .write_enable_out (write_enable_out),
    .store_enable_out (store_enable_out),
    .load_enable_out  (load_enable_out),
    .mem_addr_out     (mem_addr_out),
    .zero_flag_out    (zero_flag_out),
    .carry_flag_out   (carry_flag_out),
    .valid_out        (valid_out),
    .stall_out        (stall_out)
  );

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] sd;
    logic [3:0]  rd;
    logic [3:0]  ma;
    logic        we;
    logic        se;
    logic        le;
    logic        z;
    logic        c;
    logic        v;
    logic        st;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  rd;
    logic        we;
    logic        se;
    logic        le;
    logic [3:0]  ma;
    exp_t        e;
  } vec_t;

  vec_t tbl [12];

  function automatic exp_t ex(input logic [15:0] res, input logic [15:0] sd,
                              input logic [3:0] rd, input logic [3:0] ma,
                              input logic we, input logic se, input logic le,
                              input logic z, input logic c, input logic v);
    exp_t e;
    e.res = res; e.sd = sd; e.rd = rd; e.ma = ma;
    e.we = we; e.se = se; e.le = le;
    e.z = z; e.c = c; e.v = v; e.st = 1'b0;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [3:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic [3:0] rd,
                               input logic we, input logic se, input logic le,
                               input logic [3:0] ma, input exp_t e);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.rd = rd;
    v.we = we; v.se = se; v.le = le; v.ma = ma; v.e = e;
    return v;
  endfunction

  function automatic exp_t bub(input logic st);
    exp_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  // Reference model for single-cycle opcodes, built from plain arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] rd,
                                 input logic we, input logic se, input logic le,
                                 input logic [3:0] ma);
    exp_t e;
    int unsigned ua, ub, r, sh;
    bit retire;
    e = '0;
    ua = a; ub = b; sh = ub % 16; r = 0; retire = 1;
    case (op)
      4'h1: begin r = ua + ub; e.c = (r > 65535); end
      4'h2: begin r = ua - ub; e.c = (ua < ub); end
      4'h3: r = ua & ub;
      4'h4: r = ua | ub;
      4'h5: r = ua ^ ub;
      4'h6: r = 65535 - ua;
      4'h7: r = ua * (1 << sh);
      4'h8: r = ua / (1 << sh);
      4'hA: r = 0;
      4'hB: begin r = 0; e.sd = a; end
      4'hC: r = ub;
      default: retire = 0;
    endcase
    if (!retire) return bub(1'b0);
    e.res = 16'(r % 65536);
    e.z = (e.res == 16'd0);
    e.v = 1'b1;
    e.rd = rd; e.ma = ma;
    e.we = we; e.se = se; e.le = le;
    return e;
  endfunction

  function automatic exp_t mul_exp(input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] rd, input logic we);
    exp_t e;
    int unsigned p;
    e = '0;
    p = int'(a) * int'(b);
    e.res = 16'(p % 65536);
    e.c = (p > 65535);
    e.z = (e.res == 16'd0);
    e.v = 1'b1;
    e.rd = rd;
    e.we = we;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic check_out(input string t, input exp_t e);
    chk({t, ".res"},   32'(alu_result_out),   32'(e.res));
    chk({t, ".sd"},    32'(store_data_out),   32'(e.sd));
    chk({t, ".rd"},    32'(reg_addr_out),     32'(e.rd));
    chk({t, ".ma"},    32'(mem_addr_out),     32'(e.ma));
    chk({t, ".we"},    32'(write_enable_out), 32'(e.we));
    chk({t, ".se"},    32'(store_enable_out), 32'(e.se));
    chk({t, ".le"},    32'(load_enable_out),  32'(e.le));
    chk({t, ".zero"},  32'(zero_flag_out),    32'(e.z));
    chk({t, ".carry"}, 32'(carry_flag_out),   32'(e.c));
    chk({t, ".valid"}, 32'(valid_out),        32'(e.v));
    chk({t, ".stall"}, 32'(stall_out),        32'(e.st));
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] rd,
                       input logic we, input logic se, input logic le,
                       input logic [3:0] ma);
    opcode_in = op;
    operand1_in = a;
    operand2_in = b;
    reg_addr_in = rd;
    write_enable_in = we;
    store_enable_in = se;
    load_enable_in = le;
    mem_addr_in = ma;
  endtask

  task automatic rand_inputs();
    drive(4'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a MUL from idle, scramble inputs while stalled, check every cycle.
  task automatic run_mul(input string t, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] rd,
                         input logic we);
    drive(4'h9, a, b, rd, we, 1'b1, 1'b1, 4'hF);
    step();
    check_out({t, ".e0"}, bub(1'b1));
    for (int i = 1; i <= 15; i++) begin
      rand_inputs();
      step();
      check_out($sformatf("%s.e%0d", t, i), bub(1'b1));
    end
    rand_inputs();
    step();
    check_out({t, ".e16"}, mul_exp(a, b, rd, we));
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [3:0]  rd, ma;
    logic        we, se, le;

    tbl[0]  = mkv(4'h1, 16'hFFFF, 16'h0001, 4'd3, 1, 0, 0, 4'd0,
                  ex(16'h0000, 16'h0, 4'd3, 4'd0, 1, 0, 0, 1, 1, 1));
    tbl[1]  = mkv(4'h2, 16'h0005, 16'h0007, 4'd2, 1, 0, 0, 4'd0,
                  ex(16'hFFFE, 16'h0, 4'd2, 4'd0, 1, 0, 0, 0, 1, 1));
    tbl[2]  = mkv(4'h7, 16'h0001, 16'h0004, 4'd1, 1, 0, 0, 4'd0,
                  ex(16'h0010, 16'h0, 4'd1, 4'd0, 1, 0, 0, 0, 0, 1));
    tbl[3]  = mkv(4'hB, 16'hABCD, 16'h0000, 4'd0, 0, 1, 0, 4'd9,
                  ex(16'h0000, 16'hABCD, 4'd0, 4'd9, 0, 1, 0, 1, 0, 1));
    tbl[4]  = mkv(4'hF, 16'h1234, 16'h5678, 4'd6, 1, 1, 1, 4'd3,
                  ex(16'h0000, 16'h0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0));
    tbl[5]  = mkv(4'hA, 16'h1111, 16'h2222, 4'd4, 1, 0, 1, 4'd5,
                  ex(16'h0000, 16'h0, 4'd4, 4'd5, 1, 0, 1, 1, 0, 1));
    tbl[6]  = mkv(4'hC, 16'h0000, 16'h1234, 4'd7, 1, 0, 0, 4'd0,
                  ex(16'h1234, 16'h0, 4'd7, 4'd0, 1, 0, 0, 0, 0, 1));
    tbl[7]  = mkv(4'h6, 16'hFFFF, 16'h0000, 4'd8, 1, 0, 0, 4'd0,
                  ex(16'h0000, 16'h0, 4'd8, 4'd0, 1, 0, 0, 1, 0, 1));
    tbl[8]  = mkv(4'h8, 16'h8000, 16'h001F, 4'd9, 1, 0, 0, 4'd0,
                  ex(16'h0001, 16'h0, 4'd9, 4'd0, 1, 0, 0, 0, 0, 1));
    tbl[9]  = mkv(4'h0, 16'h0005, 16'h0005, 4'd5, 1, 1, 1, 4'd5,
                  ex(16'h0000, 16'h0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0));
    tbl[10] = mkv(4'h1, 16'h7FFF, 16'h0001, 4'd2, 1, 0, 0, 4'd0,
                  ex(16'h8000, 16'h0, 4'd2, 4'd0, 1, 0, 0, 0, 0, 1));
    tbl[11] = mkv(4'h2, 16'h0007, 16'h0007, 4'd2, 1, 0, 0, 4'd0,
                  ex(16'h0000, 16'h0, 4'd2, 4'd0, 1, 0, 0, 1, 0, 1));

    // reset holds everything at zero regardless of clock or inputs
    reset = 1'b1;
    rand_inputs();
    #1;
    check_out("reset_async", bub(1'b0));
    step();
    step();
    check_out("reset_clocked", bub(1'b0));
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd,
            tbl[i].we, tbl[i].se, tbl[i].le, tbl[i].ma);
      step();
      check_out($sformatf("vec%0d", i), tbl[i].e);
    end

    run_mul("mul300", 16'd300, 16'd300, 4'd6, 1'b1);
    drive(4'h0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check_out("mul300.after", bub(1'b0));

    run_mul("mul_zero", 16'hABCD, 16'h0000, 4'd2, 1'b1);
    run_mul("mul_max", 16'hFFFF, 16'hFFFF, 4'd1, 1'b0);

    // ADD held on the inputs during the stall retires right after the MUL
    drive(4'h9, 16'd3, 16'd4, 4'd5, 1, 0, 0, 0);
    step();
    check_out("hold.e0", bub(1'b1));
    drive(4'h1, 16'd1, 16'd1, 4'd6, 1, 0, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      step();
      check_out($sformatf("hold.e%0d", i), bub(1'b1));
    end
    step();
    check_out("hold.mul", mul_exp(16'd3, 16'd4, 4'd5, 1'b1));
    step();
    check_out("hold.add", model(4'h1, 16'd1, 16'd1, 4'd6, 1, 0, 0, 0));
    drive(4'h0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check_out("hold.after", bub(1'b0));

    // back-to-back MULs: stall drops for exactly one cycle
    drive(4'h9, 16'd7, 16'd9, 4'd3, 1, 0, 0, 0);
    step();
    check_out("b2b.a.e0", bub(1'b1));
    drive(4'h9, 16'd2, 16'd5, 4'd4, 1, 0, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      step();
      check_out($sformatf("b2b.a.e%0d", i), bub(1'b1));
    end
    step();
    check_out("b2b.a.res", mul_exp(16'd7, 16'd9, 4'd3, 1'b1));
    step();
    check_out("b2b.b.e0", bub(1'b1));
    for (int i = 1; i <= 15; i++) begin
      rand_inputs();
      step();
      check_out($sformatf("b2b.b.e%0d", i), bub(1'b1));
    end
    rand_inputs();
    step();
    check_out("b2b.b.res", mul_exp(16'd2, 16'd5, 4'd4, 1'b1));

    // reset in the middle of a multiply aborts it
    drive(4'h9, 16'd1234, 16'd5678, 4'd7, 1, 0, 0, 0);
    step();
    for (int i = 1; i <= 8; i++) begin
      step();
      check_out($sformatf("abort.e%0d", i), bub(1'b1));
    end
    reset = 1'b1;
    #1;
    check_out("abort.reset", bub(1'b0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(4'h1, 16'd2, 16'd3, 4'd1, 1, 0, 0, 0);
    step();
    check_out("abort.add", model(4'h1, 16'd2, 16'd3, 4'd1, 1, 0, 0, 0));
    drive(4'h0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      check_out($sformatf("abort.quiet%0d", i), bub(1'b0));
    end

    // randomized traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      rd = 4'($urandom);
      ma = 4'($urandom);
      we = 1'($urandom);
      se = 1'($urandom);
      le = 1'($urandom);
      if (op == 4'h9) begin
        run_mul($sformatf("rnd%0d.mul", i), a, b, rd, we);
      end else begin
        drive(op, a, b, rd, we, se, le, ma);
        step();
        check_out($sformatf("rnd%0d.op%0h", i, op),
                  model(op, a, b, rd, we, se, le, ma));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
